// File: rtl/register_rename.sv
// Register rename stage feeding the reorder buffer.
// Architectural sources and destinations are mapped onto physical registers
// through a register alias table (RAT). New destinations are drawn from a
// circular free list that retirement refills through two free ports.
module register_rename #(
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHYS = 64,
    parameter int PREG_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_has_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [6:0]        out_opcode,
    output logic [PREG_W-1:0] out_ps1,
    output logic [PREG_W-1:0] out_ps2,
    output logic [PREG_W-1:0] out_dr,
    output logic [PREG_W-1:0] out_old_dr,
    input  logic              free_valid_0,
    input  logic [PREG_W-1:0] free_preg_0,
    input  logic              free_valid_1,
    input  logic [PREG_W-1:0] free_preg_1,
    output logic [PREG_W:0]   free_count
);

    localparam int COUNT_W = PREG_W + 1;
    localparam logic [COUNT_W-1:0] FULL_COUNT  = COUNT_W'(NUM_PHYS);
    localparam logic [COUNT_W-1:0] RESET_COUNT = COUNT_W'(NUM_PHYS - NUM_ARCH);
    localparam logic [PREG_W-1:0]  RESET_TAIL  = PREG_W'(NUM_ARCH);
    localparam logic [PREG_W-1:0]  PTR_ONE     = PREG_W'(1);

    logic [PREG_W-1:0]  rat_q      [NUM_ARCH];
    logic [PREG_W-1:0]  rat_d      [NUM_ARCH];
    logic [PREG_W-1:0]  freelist_q [NUM_PHYS];
    logic [PREG_W-1:0]  freelist_d [NUM_PHYS];
    logic [PREG_W-1:0]  head_q, head_d;
    logic [PREG_W-1:0]  tail_q, tail_d;
    logic [COUNT_W-1:0] free_count_q, free_count_d;

    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_pc_q, out_pc_d;
    logic [6:0]         out_opcode_q, out_opcode_d;
    logic [PREG_W-1:0]  out_ps1_q, out_ps1_d;
    logic [PREG_W-1:0]  out_ps2_q, out_ps2_d;
    logic [PREG_W-1:0]  out_dr_q, out_dr_d;
    logic [PREG_W-1:0]  out_old_dr_q, out_old_dr_d;

    logic               needs_alloc;
    logic               accept;
    logic               do_alloc;
    logic [PREG_W-1:0]  src1_preg;
    logic [PREG_W-1:0]  src2_preg;
    logic [PREG_W-1:0]  alloc_preg;
    logic [COUNT_W-1:0] count_work;

    // Handshake: accept when the output slot frees up this cycle and, for a
    // writer, the free list is non-empty (frees arriving now do not count).
    always_comb begin
        needs_alloc = in_has_rd && (in_rd != 5'd0);
        in_ready    = (!out_valid_q || out_ready) &&
                      (!needs_alloc || (free_count_q != '0));
        accept      = in_valid && in_ready;
        do_alloc    = accept && needs_alloc;
    end

    // Source lookup uses the table as it stood before this cycle's update;
    // x0 is hardwired to physical register 0.
    always_comb begin
        src1_preg  = (in_rs1 == 5'd0) ? '0 : rat_q[in_rs1];
        src2_preg  = (in_rs2 == 5'd0) ? '0 : rat_q[in_rs2];
        alloc_preg = freelist_q[head_q];
    end

    // Allocation: pop the head of the free list and remap the destination.
    always_comb begin
        rat_d  = rat_q;
        head_d = head_q;
        if (do_alloc) begin
            rat_d[in_rd] = alloc_preg;
            head_d       = head_q + PTR_ONE;
        end
    end

    // Frees: port 0 is appended before port 1; preg 0 is never a real free
    // and frees that would push the list past full are dropped.
    always_comb begin
        freelist_d = freelist_q;
        tail_d     = tail_q;
        count_work = free_count_q - COUNT_W'(do_alloc);
        if (free_valid_0 && (free_preg_0 != '0) && (count_work < FULL_COUNT)) begin
            freelist_d[tail_d] = free_preg_0;
            tail_d             = tail_d + PTR_ONE;
            count_work         = count_work + COUNT_W'(1);
        end
        if (free_valid_1 && (free_preg_1 != '0) && (count_work < FULL_COUNT)) begin
            freelist_d[tail_d] = free_preg_1;
            tail_d             = tail_d + PTR_ONE;
            count_work         = count_work + COUNT_W'(1);
        end
        free_count_d = count_work;
    end

    // Output register: load on accept, drop valid once consumed, else hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_opcode_d = out_opcode_q;
        out_ps1_d    = out_ps1_q;
        out_ps2_d    = out_ps2_q;
        out_dr_d     = out_dr_q;
        out_old_dr_d = out_old_dr_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_pc_d     = in_pc;
            out_opcode_d = in_opcode;
            out_ps1_d    = src1_preg;
            out_ps2_d    = src2_preg;
            out_dr_d     = needs_alloc ? alloc_preg : '0;
            out_old_dr_d = needs_alloc ? rat_q[in_rd] : '0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset restores the identity map and a free list
    // holding the upper half of the physical file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                rat_q[i] <= PREG_W'(i);
            end
            for (int i = 0; i < NUM_PHYS; i++) begin
                freelist_q[i] <= PREG_W'(i + NUM_ARCH);
            end
            head_q       <= '0;
            tail_q       <= RESET_TAIL;
            free_count_q <= RESET_COUNT;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_opcode_q <= '0;
            out_ps1_q    <= '0;
            out_ps2_q    <= '0;
            out_dr_q     <= '0;
            out_old_dr_q <= '0;
        end else begin
            rat_q        <= rat_d;
            freelist_q   <= freelist_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            free_count_q <= free_count_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_opcode_q <= out_opcode_d;
            out_ps1_q    <= out_ps1_d;
            out_ps2_q    <= out_ps2_d;
            out_dr_q     <= out_dr_d;
            out_old_dr_q <= out_old_dr_d;
        end
    end

    // Output port connections.
    always_comb begin
        out_valid  = out_valid_q;
        out_pc     = out_pc_q;
        out_opcode = out_opcode_q;
        out_ps1    = out_ps1_q;
        out_ps2    = out_ps2_q;
        out_dr     = out_dr_q;
        out_old_dr = out_old_dr_q;
        free_count = free_count_q;
    end

endmodule

// File: doc/register_rename.md
Name: register_rename

Overview:
- Rename stage directly upstream of the reorder buffer.
- Maps 5-bit architectural sources and destinations onto 6-bit physical registers using a register alias table (RAT) and a circular free list.
- Emits the new and old destination physical registers (dr / old_dr) that the ROB records.
- Accepts up to two physical-register frees per cycle from retirement.

Parameters:
- NUM_ARCH, 32, architectural registers (x0..x31).
- NUM_PHYS, 64, physical registers; free-list depth equals NUM_PHYS.
- PREG_W, 6, physical register index width (log2 NUM_PHYS).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept this cycle.
- in_pc  input  32  instruction PC.
- in_opcode  input  7  instruction opcode.
- in_rs1  input  5  architectural source 1.
- in_rs2  input  5  architectural source 2.
- in_rd  input  5  architectural destination.
- in_has_rd  input  1  instruction writes rd (0 for store/branch).
- out_valid  output  1  renamed instruction valid.
- out_ready  input  1  ROB/dispatch accepts output.
- out_pc  output  32  registered PC.
- out_opcode  output  7  registered opcode.
- out_ps1  output  6  physical source 1.
- out_ps2  output  6  physical source 2.
- out_dr  output  6  newly allocated physical destination.
- out_old_dr  output  6  previous mapping of rd.
- free_valid_0  input  1  retire free port 0.
- free_preg_0  input  6  physical register to free, port 0.
- free_valid_1  input  1  retire free port 1.
- free_preg_1  input  6  physical register to free, port 1.
- free_count  output  7  registers currently on free list (0..64).

Behaviour:
- Reset (async, rst=1):
  - RAT[i]=i for i=0..31.
  - Free list holds 32..63 in order; head=0, tail=32 (mod 64), free_count=32.
  - out_valid=0; out_pc=0, out_opcode=0, out_ps1=0, out_ps2=0, out_dr=0, out_old_dr=0.
  - Reset mid-operation discards the held output and any in-flight frees.
- needs_alloc = in_has_rd && in_rd!=0.
- in_ready = (!out_valid || out_ready) && (!needs_alloc || free_count!=0). Combinational.
- Accept = in_valid && in_ready. On accept, output registers load at the next edge (1-cycle latency) and out_valid=1.
- Renaming:
  - out_ps1=RAT[in_rs1], out_ps2=RAT[in_rs2], read before this cycle's RAT update.
  - rs==0 always yields 0.
- Allocation on accept with needs_alloc:
  - out_dr=freelist[head], out_old_dr=RAT[in_rd].
  - RAT[in_rd]<=freelist[head]; head<=head+1 mod 64.
- Accept without needs_alloc: out_dr=0, out_old_dr=0; RAT and head unchanged.
- Output hold: out_valid && !out_ready and no accept → all outputs hold. out_valid clears when out_ready=1 and no new accept.
- Frees:
  - Each asserted free port writes freelist[tail] in order: port 0 first, then port 1. Tail advances by the number of valid frees.
  - free_preg==0 is ignored: no write, no count change.
- free_count_next = free_count − alloc + frees, with alloc∈{0,1} and frees∈{0,1,2}. Simultaneous alloc and frees are legal.
- A register freed in cycle N is allocatable from cycle N+1 only; there is no same-cycle bypass when the list is empty.
- Overflow: frees pushing free_count above 64 is a protocol error. The bench flags it; the RTL saturates at 64 and drops the excess.
- Pointers wrap 63→0. head==tail is disambiguated by free_count (0 = empty, 64 = full).

Test Plan:
- Reset, then rename add x5 with rs1=x1, rs2=x2, out_ready=1 → one cycle later: out_valid=1, ps1=1, ps2=2, dr=32, old_dr=5, free_count=31.
- Back-to-back writes of x5 then a read of x5 → second instr dr=33, old_dr=32; third instr ps1=33.
- Store (in_has_rd=0) and write to x0 → dr=0, old_dr=0, free_count unchanged, RAT[0] stays 0.
- Allocate 32 consecutive writers → free_count=0, in_ready=0 on the 33rd. Free port 0 with preg 5 → in_ready=1 the next cycle and the 33rd gets dr=5.
- Hold out_ready=0 with out_valid=1 for 3 cycles → outputs stable, in_ready=0. Release → next instruction accepted in the same cycle.
- Same cycle: allocate plus free_valid_0=1 (preg 7) and free_valid_1=1 (preg 9) at free_count=10 → free_count=11, with 7 then 9 appended at the tail. Assert rst mid-stream → free_count=32 and out_valid=0 immediately.
